// File: rtl/register_reader_pkg.sv
// register_reader_pkg: PCA9685 register map constants, reader states and pointer rule.
package register_reader_pkg;
  localparam logic [7:0] PCA_MODE1         = 8'h00;
  localparam int         PCA_MODE1_AI      = 5;
  localparam logic [7:0] PCA_LED_15_OFF_H  = 8'h45;
  localparam logic [7:0] PCA_RSVD_LO       = 8'h46;
  localparam logic [7:0] PCA_RSVD_HI       = 8'hF9;
  localparam logic [7:0] PCA_ALL_LED_ON_L  = 8'hFA;
  localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'hFD;
  localparam logic [7:0] PCA_PRE_SCALE     = 8'hFE;
  // Blob is MSB-first per byte, so register bit b sits at blob offset 7-b.
  localparam int AI_BLOB_IDX = int'(PCA_MODE1) * 8 + 7 - PCA_MODE1_AI;
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_e;
  function automatic logic [7:0] next_ptr(input logic [7:0] p, input logic ai, input logic [7:0] wrap);
    return !ai ? p : (p == wrap ? 8'h00 : p + 8'h01);
  endfunction
endpackage

// File: rtl/register_byte_mux.sv
// register_byte_mux: selects the pointed register byte, zeroing reserved and write-only addresses.
module register_byte_mux
  import register_reader_pkg::*;
#(
  parameter int BLOB_BITS = 2048
) (
  input  logic [7:0]           ptr_i,
  input  logic [0:BLOB_BITS-1] blob_i,
  output logic [7:0]           byte_o
);
  logic [7:0] raw;
  logic       rsvd;
  logic       wonly;
  assign raw    = blob_i[{ptr_i, 3'b000} +: 8];
  assign rsvd   = ptr_i >= PCA_RSVD_LO && ptr_i <= PCA_RSVD_HI;
  assign wonly  = ptr_i >= PCA_ALL_LED_ON_L && ptr_i <= PCA_ALL_LED_OFF_H;
  assign byte_o = (rsvd || wonly) ? 8'h00 : raw;
endmodule

// File: rtl/register_reader.sv
// register_reader: I2C read-side pointer and one-byte prefetch with PCA9685 auto-increment.
module register_reader
  import register_reader_pkg::*;
#(
  parameter int         BLOB_BITS     = 2048,
  parameter logic [7:0] AUTO_WRAP_REG = 8'h45
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [0:BLOB_BITS-1] register_blob_i,
  input  logic                 ptr_load_i,
  input  logic [7:0]           ptr_value_i,
  input  logic                 write_strobe_i,
  input  logic                 read_start_i,
  input  logic                 byte_take_i,
  input  logic                 i2c_stopped,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  output logic [7:0]           pointer_o,
  output logic                 underrun_o
);
  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] byte_q, byte_d;
  logic       und_q, und_d;
  logic [7:0] mux_byte;
  logic [7:0] nxt;
  register_byte_mux #(.BLOB_BITS(BLOB_BITS)) u_mux (
    .ptr_i (ptr_q),
    .blob_i(register_blob_i),
    .byte_o(mux_byte)
  );
  assign nxt = next_ptr(ptr_q, register_blob_i[AI_BLOB_IDX], AUTO_WRAP_REG);
  // A pending fetch always lands in byte_q; higher-priority events only redirect the state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    und_d   = und_q;
    if (state_q == FETCH) begin
      byte_d  = mux_byte;
      state_d = READY;
    end
    if (i2c_stopped) begin
      state_d = IDLE;
      ptr_d   = ptr_load_i ? ptr_value_i : ptr_q;
    end else if (ptr_load_i) begin
      ptr_d   = ptr_value_i;
      state_d = state_q == IDLE ? IDLE : FETCH;
    end else if (byte_take_i) begin
      if (state_q == READY) begin
        ptr_d   = nxt;
        state_d = FETCH;
      end else begin
        und_d = 1'b1;
      end
    end else if (write_strobe_i) begin
      ptr_d = state_q == IDLE ? nxt : ptr_q;
    end else if (read_start_i) begin
      und_d   = 1'b0;
      state_d = state_q == IDLE ? FETCH : state_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 8'h00;
      byte_q  <= 8'h00;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      und_q   <= und_d;
    end
  end
  assign byte_o       = byte_q;
  assign byte_valid_o = state_q == READY;
  assign pointer_o    = ptr_q;
  assign underrun_o   = und_q;
endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed table, AI=0 sequence and randomized run against a reference model.
module tb_register_reader;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:2047] blob = '0;
  logic          ld = 1'b0, wr = 1'b0, rs = 1'b0, tk = 1'b0, st = 1'b0;
  logic [7:0]    pv = 8'h00;
  logic [7:0]    byte_o, pointer_o;
  logic          valid_o, und_o;
  int            checks = 0;
  int            failures = 0;

  register_reader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .register_blob_i(blob),
    .ptr_load_i     (ld),
    .ptr_value_i    (pv),
    .write_strobe_i (wr),
    .read_start_i   (rs),
    .byte_take_i    (tk),
    .i2c_stopped    (st),
    .byte_o         (byte_o),
    .byte_valid_o   (valid_o),
    .pointer_o      (pointer_o),
    .underrun_o     (und_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = fetching, 2 = byte ready.
  typedef struct {
    int         ph;
    int         ptr;
    logic [7:0] byt;
    logic       und;
  } mst_t;
  mst_t m = '{0, 0, 8'h00, 1'b0};

  function automatic logic [7:0] reg_value(logic [0:2047] b, int p);
    return (p <= 'h45 || p >= 'hFE) ? b[p*8 +: 8] : 8'h00;
  endfunction

  function automatic mst_t model_step(mst_t s, logic r, logic l, logic [7:0] v, logic w,
                                      logic rd, logic t, logic sp, logic [0:2047] b);
    mst_t n = s;
    int nx = b[2] ? (s.ptr == 'h45 ? 0 : (s.ptr + 1) % 256) : s.ptr;
    if (r) return '{0, 0, 8'h00, 1'b0};
    if (s.ph == 1) begin
      n.byt = reg_value(b, s.ptr);
      n.ph = 2;
    end
    if (sp) begin
      n.ph = 0;
      if (l) n.ptr = int'(v);
    end else if (l) begin
      n.ptr = int'(v);
      n.ph = (s.ph == 0) ? 0 : 1;
    end else if (t) begin
      if (s.ph == 2) begin
        n.ptr = nx;
        n.ph = 1;
      end else n.und = 1'b1;
    end else if (w) begin
      if (s.ph == 0) n.ptr = nx;
    end else if (rd) begin
      n.und = 1'b0;
      if (s.ph == 0) n.ph = 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, ld, pv, wr, rs, tk, st, blob);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [7:0] v, input logic w,
                     input logic rd, input logic t, input logic sp);
    rst = r; ld = l; pv = v; wr = w; rs = rd; tk = t; st = sp;
    @(posedge clk);
    @(negedge clk);
    rst = 0; ld = 0; wr = 0; rs = 0; tk = 0; st = 0;
  endtask

  task automatic set_reg(input int n, input logic [7:0] val);
    blob[n*8 +: 8] = val;
  endtask

  typedef struct {
    logic       r, l;
    logic [7:0] v;
    logic       w, rd, t, sp;
    logic [7:0] eptr;
    logic       evalid;
    logic [7:0] ebyte;
    logic       eund;
  } vec_t;

  initial begin
    vec_t tbl[$];
    set_reg('h00, 8'h20); set_reg('h06, 8'hA5); set_reg('h08, 8'h33);
    set_reg('h0A, 8'h5C); set_reg('h44, 8'h11); set_reg('h45, 8'h22);
    set_reg('h50, 8'h55); set_reg('hFA, 8'h77); set_reg('hFE, 8'h1E);
    set_reg('hFF, 8'h99);
    //          r  l  v      w  rd t  sp  eptr   ev eb     eu
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'h06, 0, 0, 0, 0, 8'h06, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h06, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h06, 1, 8'hA5, 0});
    tbl.push_back('{0, 1, 8'h44, 0, 0, 0, 0, 8'h44, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h44, 1, 8'h11, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h45, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h45, 1, 8'h22, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h20, 0});
    tbl.push_back('{0, 1, 8'hFA, 0, 0, 0, 0, 8'hFA, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'hFA, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 8'h50, 0, 0, 0, 0, 8'h50, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h50, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 8'hFE, 0, 0, 0, 0, 8'hFE, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'hFE, 1, 8'h1E, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'hFF, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 1, 8'h99, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h20, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 8'h20, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 8'h20, 0});
    tbl.push_back('{0, 1, 8'h30, 0, 0, 0, 1, 8'h30, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h30, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'h06, 0, 0, 0, 0, 8'h06, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 8'h07, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 8'h08, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 8'h09, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 8'h0A, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h0A, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h0A, 1, 8'h5C, 0});
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0});
    @(negedge clk);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].w, tbl[i].rd, tbl[i].t, tbl[i].sp);
      chk($sformatf("row%0d ptr", i), pointer_o, tbl[i].eptr);
      chk($sformatf("row%0d valid", i), valid_o, tbl[i].evalid);
      chk($sformatf("row%0d underrun", i), und_o, tbl[i].eund);
      if (tbl[i].evalid || tbl[i].r) chk($sformatf("row%0d byte", i), byte_o, tbl[i].ebyte);
    end

    // AI = 0: takes re-read the same register; prefetched byte ignores blob changes.
    set_reg('h00, 8'h00);
    cyc(0, 1, 8'h08, 0, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ai0 byte%0d", k), byte_o, 8'h33);
      chk($sformatf("ai0 valid%0d", k), valid_o, 1'b1);
      cyc(0, 0, 8'h00, 0, 0, 1, 0);
      chk($sformatf("ai0 ptr%0d", k), pointer_o, 8'h08);
      chk($sformatf("ai0 gap%0d", k), valid_o, 1'b0);
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
    end
    set_reg('h08, 8'hEE);
    cyc(0, 0, 8'h00, 0, 0, 0, 0);
    chk("stable byte", byte_o, 8'h33);
    cyc(0, 0, 8'h00, 0, 0, 1, 0);
    cyc(0, 0, 8'h00, 0, 0, 0, 0);
    chk("refetch byte", byte_o, 8'hEE);
    cyc(1, 0, 8'h00, 0, 0, 0, 0);
    chk("reset from ready ptr", pointer_o, 8'h00);
    chk("reset from ready valid", valid_o, 1'b0);

    // Randomized run against the model.
    for (int n = 0; n < 256; n++) set_reg(n, 8'($urandom));
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] picks[4];
      picks[0] = 8'($urandom); picks[1] = 8'h44; picks[2] = 8'hFE; picks[3] = 8'hF9;
      if ($urandom_range(7) == 0) set_reg($urandom_range(255), 8'($urandom));
      if ($urandom_range(15) == 0) blob[2] = ~blob[2];
      cyc($urandom_range(199) == 0, $urandom_range(11) == 0, picks[$urandom_range(3)],
          $urandom_range(5) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0,
          $urandom_range(19) == 0);
      chk("rand ptr", pointer_o, 32'(m.ptr));
      chk("rand valid", valid_o, m.ph == 2);
      chk("rand underrun", und_o, m.und);
      if (m.ph == 2) chk("rand byte", byte_o, m.byt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
